// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: N-way WIDTH-bit registered selector with a valid/ready
// handshake. A main register drives the outputs, and a skid register holds one
// extra beat while downstream stalls. in_ready is registered, so out_ready has
// no combinational path to it. Selects of N or above are illegal. An illegal
// beat still travels through the stage carrying zero data, and it raises a
// sticky flag and bumps a saturating counter.
module mux_pipe_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic [SELW-1:0]      out_sel,
  input  logic                 clr_err,
  output logic                 sel_err,
  output logic [7:0]           err_cnt
);

  // Reject illegal parameter combinations at elaboration.
  if (N < 2 || N > 16 || SELW < 1 || (2 ** SELW) < N) begin : g_param_check
    $error("mux_pipe_stage: illegal parameters (need 2 <= N <= 16, 2**SELW >= N)");
  end

  // Occupancy of the two-entry buffer.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SELW-1:0]  main_sel_q, main_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SELW-1:0]  skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] pick_word;
  logic             pick_hit;
  logic             pick_illegal;
  logic             accept;
  logic             pop;

  assign out_valid    = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign accept       = in_valid && in_ready_q;
  assign pop          = out_valid && out_ready;
  assign pick_illegal = !pick_hit;

  // Pick the addressed channel. An index with no matching channel yields zero.
  always_comb begin
    pick_word = '0;
    pick_hit  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        pick_word = data_in[k*WIDTH +: WIDTH];
        pick_hit  = 1'b1;
      end
    end
  end

  // Buffer occupancy and entry movement. Only the chosen word is stored.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = pick_word;
          main_sel_d  = sel;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_data_d = pick_word;
          main_sel_d  = sel;
        end else if (accept) begin
          skid_data_d = pick_word;
          skid_sel_d  = sel;
          state_d     = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  // Error tracking. A clear applies first, so an illegal beat in the same
  // cycle leaves the flag set and the count at one.
  always_comb begin
    sel_err_d = sel_err_q;
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      sel_err_d = 1'b0;
      err_cnt_d = '0;
    end
    if (accept && pick_illegal) begin
      sel_err_d = 1'b1;
      if (err_cnt_d != 8'hFF) begin
        err_cnt_d = err_cnt_d + 8'd1;
      end
    end
  end

  // State registers with synchronous reset. Reset also clears the skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign data_out = main_data_q;
  assign out_sel  = main_sel_q;
  assign sel_err  = sel_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: doc/mux_pipe_stage.md
Name: mux_pipe_stage

Overview:
- Parametrised N-way, WIDTH-bit registered selector. Next generation of the datapath 2:1 selectors, intended for the pipelined core upgrade (operand, write-back and PC-source selection between stages).
- Adds a valid/ready handshake with a 2-entry skid buffer, so full throughput is sustained under downstream stalls.
- Adds illegal-select detection, with a sticky flag and a saturating error counter.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels (2..16).
- SELW, 2, select width; must be at least ceil(log2(N)) and at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream holds sel and data_in valid.
- in_ready  output  1  stage can accept a beat this cycle.
- sel  input  SELW  channel index; sampled on accept.
- data_in  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  data_out and out_sel are valid.
- out_ready  input  1  downstream accepts the beat.
- data_out  output  WIDTH  selected channel data.
- out_sel  output  SELW  sel value that produced data_out.
- clr_err  input  1  clears sel_err and err_cnt.
- sel_err  output  1  sticky: an illegal sel was accepted.
- err_cnt  output  8  saturating count of accepted illegal selects.

Behaviour:
- Accept condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- On accept, the stage captures the selected word (data_in channel sel) and sel into the next free entry. Only the selected word is stored, never the whole bus.
- Illegal select: sel >= N (possible only when N < 2**SELW). The stored data is all-zero, out_sel is the illegal value, and the beat still flows through the handshake.
- Storage: a main register drives the outputs; a skid register catches one beat when downstream stalls.
- State machine: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept only -> TWO (beat goes to skid). Pop only -> EMPTY. Accept and pop together -> ONE (main reloaded with the new beat).
  - TWO: accept is impossible. Pop -> ONE (skid moves to main).
- in_ready is a register output, high in EMPTY and ONE, low in TWO. No combinational path from out_ready to in_ready.
- out_valid is high in ONE and TWO.
- Latency: 1 cycle. A beat accepted at edge t is visible on data_out after edge t.
- Throughput: 1 beat/cycle while out_ready is held high.
- Beats leave in acceptance order; none are dropped or duplicated.
- While out_valid is high and out_ready is low, data_out and out_sel hold stable.
- Errors:
  - On an accepted illegal beat, sel_err is set, and err_cnt increments, saturating at 255.
  - clr_err zeroes both.
  - clr_err together with an accepted illegal beat: sel_err = 1, err_cnt = 1 (the new error wins).
  - Illegal sel with in_valid low, or while in_ready is low, is ignored.
- Reset:
  - State EMPTY; in_ready = 1 from the first cycle after reset; out_valid = 0; data_out = 0; out_sel = 0; sel_err = 0; err_cnt = 0.
  - Reset mid-operation discards all buffered beats. The skid register is also cleared to 0.
- Parameter legality: elaboration fails if N < 2, N > 16, or 2**SELW < N.

Test Plan:
- Reset then stream (N=4, WIDTH=32, out_ready=1): channels = {0x11111111, 0x22222222, 0x33333333, 0x44444444}; sel sequence 0,3,1,2 on consecutive cycles -> data_out one cycle later is 0x11111111, 0x44444444, 0x22222222, 0x33333333; in_ready stays 1.
- Back-pressure: stream sel 0,1,2 with out_ready=0 -> after two accepts in_ready=0 and data_out holds 0x11111111. Raise out_ready -> outputs 0x11111111, 0x22222222, then 0x33333333 accepted and delivered; no loss, order kept.
- Simultaneous accept/pop in ONE: out_ready=1 and in_valid=1 every cycle for 10 cycles -> state never reaches TWO and 10 beats leave in 10 cycles.
- Illegal select (N=3, SELW=2): accept sel=3 -> data_out=0, out_sel=3, sel_err=1, err_cnt=1. 300 further illegal accepts -> err_cnt=255. clr_err together with an illegal accept -> sel_err=1, err_cnt=1.
- Reset mid-operation: state TWO with out_ready=0, assert rst one cycle -> out_valid=0, in_ready=1, data_out=0, err_cnt=0; next beat sel=2 emerges alone.
